// File: rtl/load_align_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// load_align_unit
//
// Memory-stage load engine. A load presented by the M stage is checked for
// alignment, turned into a single word-aligned bus read, and the addressed
// byte / halfword / word of the returned data is sign- or zero-extended into
// a registered result. The pipeline is stalled while the read is outstanding.
// An interrupt flush cancels the load without abandoning a read that is
// already on the bus, and a read that is never acknowledged times out.
//
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   LDOp         in   3   001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu, else none
//   MemA         in  32   byte address of the load
//   IntReq       in   1   flush: cancels the load in flight
//   m_rd_req     out  1   bus read request (registered)
//   m_rd_addr    out 32   word-aligned read address (registered)
//   m_rd_ack     in   1   bus acknowledge, m_rd_data valid in the same cycle
//   m_rd_data    in  32   bus read data
//   busy         out  1   pipeline stall request (combinational)
//   done         out  1   one-cycle pulse, LoadD valid
//   LoadD        out 32   extended load result, held until the next done
//   AdEL         out  1   one-cycle pulse, misaligned load address
//   BusErr       out  1   one-cycle pulse, read timed out
//   dbg_state_o  out  2   current FSM state (IDLE/WAIT/DRAIN/DONE)
//
// Bus handshake: m_rd_req is a request held high, with m_rd_addr stable,
// until the cycle in which m_rd_ack is seen high; that cycle completes the
// transfer and m_rd_data is sampled in it. A request is never withdrawn
// early except by timeout or reset. Acks seen while no request is
// outstanding are ignored.
// -----------------------------------------------------------------------------
module load_align_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  LDOp,
    input  logic [31:0] MemA,
    input  logic        IntReq,
    output logic        m_rd_req,
    output logic [31:0] m_rd_addr,
    input  logic        m_rd_ack,
    input  logic [31:0] m_rd_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] LoadD,
    output logic        AdEL,
    output logic        BusErr,
    output logic [1:0]  dbg_state_o
);

    localparam logic [2:0] OP_LW  = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LB  = 3'b100;
    localparam logic [2:0] OP_LBU = 3'b101;

    // Last counter value before the read is declared lost. The counter is
    // zero in the first request cycle, so the request stays up for exactly
    // TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       load_q, load_d;
    logic              adel_q, adel_d;
    logic              berr_q, berr_d;

    logic              op_valid;
    logic              misaligned;
    logic              accept;
    logic              accept_ok;
    logic              timeout_hit;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic [31:0]       extended;

    // -------------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // -------------------------------------------------------------------------
    always_comb begin
        op_valid   = 1'b0;
        misaligned = 1'b0;
        case (LDOp)
            OP_LW: begin
                op_valid   = 1'b1;
                misaligned = |MemA[1:0];
            end
            OP_LH, OP_LHU: begin
                op_valid   = 1'b1;
                misaligned = MemA[0];
            end
            OP_LB, OP_LBU: begin
                op_valid   = 1'b1;
            end
            default: begin
                op_valid   = 1'b0;
            end
        endcase
    end

    // A flush in the acceptance cycle suppresses the load entirely,
    // including any misalignment report.
    assign accept      = (state_q == ST_IDLE) && op_valid && !IntReq;
    assign accept_ok   = accept && !misaligned;
    assign timeout_hit = (cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // Lane extraction and extension from the live bus data, using the
    // operation and address offset latched at acceptance.
    // -------------------------------------------------------------------------
    always_comb begin
        half_sel = off_q[1] ? m_rd_data[31:16] : m_rd_data[15:0];
        byte_sel = m_rd_data[7:0];
        case (off_q)
            2'd0:    byte_sel = m_rd_data[7:0];
            2'd1:    byte_sel = m_rd_data[15:8];
            2'd2:    byte_sel = m_rd_data[23:16];
            default: byte_sel = m_rd_data[31:24];
        endcase

        extended = m_rd_data;
        case (op_q)
            OP_LH:   extended = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  extended = {16'h0000, half_sel};
            OP_LB:   extended = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  extended = {24'h000000, byte_sel};
            default: extended = m_rd_data;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM next state and datapath updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        op_d    = op_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        adel_d  = 1'b0;
        berr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        adel_d = 1'b1;
                    end else begin
                        op_d    = LDOp;
                        off_d   = MemA[1:0];
                        addr_d  = {MemA[31:2], 2'b00};
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (m_rd_ack) begin
                    req_d = 1'b0;
                    if (IntReq) begin
                        // Flush lands on the ack: the read is complete on the
                        // bus, its data is simply dropped.
                        state_d = ST_IDLE;
                    end else begin
                        load_d  = extended;
                        state_d = ST_DONE;
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    // The request is already visible to the bus and cannot
                    // be retracted, so a flush has to wait for the ack.
                    if (IntReq) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (m_rd_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            op_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            load_q  <= '0;
            adel_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            adel_q  <= adel_d;
            berr_q  <= berr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign m_rd_req    = req_q;
    assign m_rd_addr   = addr_q;
    assign LoadD       = load_q;
    assign AdEL        = adel_q;
    assign BusErr      = berr_q;
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

    // The stall is raised in the acceptance cycle itself so the M stage holds
    // while the read is set up; it is masked during reset so every output is
    // quiet while the block is held in reset.
    assign busy = reset &&
                  (accept_ok || (state_q == ST_WAIT) || (state_q == ST_DRAIN));

endmodule

// File: tb/tb_load_align_unit.sv
`timescale 1ns/1ps
module tb_load_align_unit;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;
    localparam int W       = TIMEOUT + 4;   // cycles observed per transaction

    // -------------------------------------------------------------------------
    // Clock / reset and DUT
    // -------------------------------------------------------------------------
    logic        clk;
    logic        reset;
    logic [2:0]  LDOp;
    logic [31:0] MemA;
    logic        IntReq;
    logic        m_rd_req;
    logic [31:0] m_rd_addr;
    logic        m_rd_ack;
    logic [31:0] m_rd_data;
    logic        busy;
    logic        done;
    logic [31:0] LoadD;
    logic        AdEL;
    logic        BusErr;
    logic [1:0]  dbg_state;

    load_align_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .LDOp        (LDOp),
        .MemA        (MemA),
        .IntReq      (IntReq),
        .m_rd_req    (m_rd_req),
        .m_rd_addr   (m_rd_addr),
        .m_rd_ack    (m_rd_ack),
        .m_rd_data   (m_rd_data),
        .busy        (busy),
        .done        (done),
        .LoadD       (LoadD),
        .AdEL        (AdEL),
        .BusErr      (BusErr),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_load;        // model of the value LoadD should hold

    logic        obs_req[W], obs_busy[W], obs_done[W], obs_adel[W], obs_berr[W];
    logic [31:0] obs_addr[W], obs_load[W];

    logic        exp_req[W], exp_busy[W], exp_done[W], exp_adel[W], exp_berr[W];
    logic [31:0] exp_load[W];
    logic [31:0] exp_addr;
    logic        exp_has_done;
    logic [31:0] exp_res;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic logic [31:0] ref_extend(input logic [2:0] op,
                                               input logic [1:0] off,
                                               input logic [31:0] data);
        logic [31:0] h;
        logic [31:0] b;
        h = (data >> (16 * (off / 2))) & 32'h0000_FFFF;
        b = (data >> (8 * off)) & 32'h0000_00FF;
        case (op)
            3'd1:    return data;
            3'd2:    return (h >= 32'h8000) ? h - 32'h0001_0000 : h;
            3'd3:    return h;
            3'd4:    return (b >= 32'h80) ? b - 32'h0000_0100 : b;
            3'd5:    return b;
            default: return 32'h0;
        endcase
    endfunction

    // Expected per-cycle timeline for one load presented in cycle 0, acked in
    // cycle 1+d (d >= TIMEOUT means no ack before the timeout), with IntReq
    // pulsed in cycle f (f < 0: never).
    task automatic build_expect(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input int d, input int f);
        int          a;
        logic        acc;
        logic        mis;
        logic [31:0] nl;
        for (int c = 0; c < W; c++) begin
            exp_req[c]  = 1'b0;
            exp_busy[c] = 1'b0;
            exp_done[c] = 1'b0;
            exp_adel[c] = 1'b0;
            exp_berr[c] = 1'b0;
            exp_load[c] = cur_load;
        end
        exp_addr     = {addr[31:2], 2'b00};
        exp_has_done = 1'b0;
        exp_res      = 32'h0;
        acc = (op >= 3'd1) && (op <= 3'd5) && (f != 0);
        mis = (op == 3'd1 && addr[1:0] != 2'b00) || ((op == 3'd2 || op == 3'd3) && addr[0]);
        if (acc && mis) begin
            exp_adel[1] = 1'b1;
        end else if (acc) begin
            exp_busy[0] = 1'b1;
            if (d >= TIMEOUT) begin
                for (int c = 1; c <= TIMEOUT; c++) begin
                    exp_req[c]  = 1'b1;
                    exp_busy[c] = 1'b1;
                end
                exp_berr[TIMEOUT + 1] = 1'b1;
            end else begin
                a = 1 + d;
                for (int c = 1; c <= a; c++) begin
                    exp_req[c]  = 1'b1;
                    exp_busy[c] = 1'b1;
                end
                if (!(f >= 1 && f <= a)) begin
                    nl = ref_extend(op, addr[1:0], data);
                    exp_done[a + 1] = 1'b1;
                    for (int c = a + 1; c < W; c++) exp_load[c] = nl;
                    exp_has_done = 1'b1;
                    exp_res      = nl;
                    cur_load     = nl;
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic irq,
                         input logic ack, input logic [31:0] data);
        @(posedge clk);
        #1;
        LDOp      = op;
        MemA      = addr;
        IntReq    = irq;
        m_rd_ack  = ack;
        m_rd_data = data;
        @(negedge clk);
    endtask

    // One load over a W-cycle window; junk data on non-ack cycles and a
    // stray ack in the final (idle) cycle.
    task automatic run_txn(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input int d, input int f);
        for (int c = 0; c < W; c++) begin
            drive((c == 0) ? op : 3'd0,
                  (c == 0) ? addr : $urandom(),
                  (c == f),
                  (c == 1 + d) || (c == W - 1),
                  (c == 1 + d) ? data : $urandom());
            obs_req[c]  = m_rd_req;
            obs_busy[c] = busy;
            obs_done[c] = done;
            obs_adel[c] = AdEL;
            obs_berr[c] = BusErr;
            obs_addr[c] = m_rd_addr;
            obs_load[c] = LoadD;
        end
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset     = 1'b0;
        LDOp      = 3'd0;
        MemA      = 32'h0;
        IntReq    = 1'b0;
        m_rd_ack  = 1'b0;
        m_rd_data = 32'h0;
        #12;
        n_total++; if (m_rd_req !== 1'b0) $display("FAIL reset m_rd_req got %b exp 0", m_rd_req); else n_pass++;
        n_total++; if (m_rd_addr !== 32'h0) $display("FAIL reset m_rd_addr got %h exp 0", m_rd_addr); else n_pass++;
        n_total++; if (LoadD !== 32'h0) $display("FAIL reset LoadD got %h exp 0", LoadD); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset done got %b exp 0", done); else n_pass++;
        n_total++; if (AdEL !== 1'b0) $display("FAIL reset AdEL got %b exp 0", AdEL); else n_pass++;
        n_total++; if (BusErr !== 1'b0) $display("FAIL reset BusErr got %b exp 0", BusErr); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else n_pass++;
        @(negedge clk);
        reset    = 1'b1;
        cur_load = 32'h0;
    endtask

    task automatic test_byte_loads();
        build_expect(3'd4, 32'h0000_1003, 32'h80FF_1234, 0, -1);
        run_txn(3'd4, 32'h0000_1003, 32'h80FF_1234, 0, -1);
        n_total++; if (obs_addr[1] !== 32'h0000_1000) $display("FAIL lb m_rd_addr got %h exp 00001000", obs_addr[1]); else n_pass++;
        n_total++; if (obs_req[1] !== 1'b1) $display("FAIL lb req_c1 got %b exp 1", obs_req[1]); else n_pass++;
        n_total++; if (obs_req[2] !== 1'b0) $display("FAIL lb req_after_ack got %b exp 0", obs_req[2]); else n_pass++;
        n_total++; if (obs_done[1] !== 1'b0) $display("FAIL lb done_c1 got %b exp 0", obs_done[1]); else n_pass++;
        n_total++; if (obs_done[2] !== 1'b1) $display("FAIL lb done_c2 got %b exp 1", obs_done[2]); else n_pass++;
        n_total++; if (obs_done[3] !== 1'b0) $display("FAIL lb done_c3 got %b exp 0", obs_done[3]); else n_pass++;
        n_total++; if (obs_load[2] !== 32'hFFFF_FF80) $display("FAIL lb LoadD got %h exp ffffff80", obs_load[2]); else n_pass++;

        build_expect(3'd5, 32'h0000_1003, 32'h80FF_1234, 0, -1);
        run_txn(3'd5, 32'h0000_1003, 32'h80FF_1234, 0, -1);
        n_total++; if (obs_done[2] !== 1'b1) $display("FAIL lbu done_c2 got %b exp 1", obs_done[2]); else n_pass++;
        n_total++; if (obs_load[2] !== 32'h0000_0080) $display("FAIL lbu LoadD got %h exp 00000080", obs_load[2]); else n_pass++;
    endtask

    task automatic test_half_loads();
        build_expect(3'd2, 32'h0000_2002, 32'h8001_ABCD, 3, -1);
        run_txn(3'd2, 32'h0000_2002, 32'h8001_ABCD, 3, -1);
        for (int c = 0; c <= 4; c++) begin
            n_total++; if (obs_busy[c] !== 1'b1) $display("FAIL lh busy_c%0d got %b exp 1", c, obs_busy[c]); else n_pass++;
        end
        n_total++; if (obs_busy[5] !== 1'b0) $display("FAIL lh busy_c5 got %b exp 0", obs_busy[5]); else n_pass++;
        n_total++; if (obs_done[5] !== 1'b1) $display("FAIL lh done_c5 got %b exp 1", obs_done[5]); else n_pass++;
        n_total++; if (obs_addr[4] !== 32'h0000_2000) $display("FAIL lh m_rd_addr got %h exp 00002000", obs_addr[4]); else n_pass++;
        n_total++; if (obs_load[5] !== 32'hFFFF_8001) $display("FAIL lh LoadD got %h exp ffff8001", obs_load[5]); else n_pass++;

        build_expect(3'd3, 32'h0000_2002, 32'h8001_ABCD, 3, -1);
        run_txn(3'd3, 32'h0000_2002, 32'h8001_ABCD, 3, -1);
        n_total++; if (obs_load[5] !== 32'h0000_8001) $display("FAIL lhu LoadD got %h exp 00008001", obs_load[5]); else n_pass++;
    endtask

    task automatic test_misaligned();
        int req_cnt;
        int done_cnt;
        build_expect(3'd1, 32'h0000_3001, 32'h1234_5678, 0, -1);
        run_txn(3'd1, 32'h0000_3001, 32'h1234_5678, 0, -1);
        req_cnt  = 0;
        done_cnt = 0;
        for (int c = 0; c < W; c++) begin
            if (obs_req[c] === 1'b1) req_cnt++;
            if (obs_done[c] === 1'b1) done_cnt++;
        end
        n_total++; if (obs_adel[1] !== 1'b1) $display("FAIL lw_mis AdEL_c1 got %b exp 1", obs_adel[1]); else n_pass++;
        n_total++; if (obs_adel[2] !== 1'b0) $display("FAIL lw_mis AdEL_c2 got %b exp 0", obs_adel[2]); else n_pass++;
        n_total++; if (obs_busy[0] !== 1'b0) $display("FAIL lw_mis busy_c0 got %b exp 0", obs_busy[0]); else n_pass++;
        n_total++; if (req_cnt != 0) $display("FAIL lw_mis req_cycles got %0d exp 0", req_cnt); else n_pass++;
        n_total++; if (done_cnt != 0) $display("FAIL lw_mis done_cycles got %0d exp 0", done_cnt); else n_pass++;

        build_expect(3'd2, 32'h0000_3003, 32'h1234_5678, 0, -1);
        run_txn(3'd2, 32'h0000_3003, 32'h1234_5678, 0, -1);
        n_total++; if (obs_adel[1] !== 1'b1) $display("FAIL lh_mis AdEL_c1 got %b exp 1", obs_adel[1]); else n_pass++;
        n_total++; if (obs_req[1] !== 1'b0) $display("FAIL lh_mis req_c1 got %b exp 0", obs_req[1]); else n_pass++;

        // A byte load at an odd address is legal.
        build_expect(3'd4, 32'h0000_3003, 32'h7A00_0000, 0, -1);
        run_txn(3'd4, 32'h0000_3003, 32'h7A00_0000, 0, -1);
        n_total++; if (obs_adel[1] !== 1'b0) $display("FAIL lb_odd AdEL_c1 got %b exp 0", obs_adel[1]); else n_pass++;
        n_total++; if (obs_load[2] !== 32'h0000_007A) $display("FAIL lb_odd LoadD got %h exp 0000007a", obs_load[2]); else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        int          done_cnt;
        prev = cur_load;
        build_expect(3'd1, 32'h0000_4000, 32'hDEAD_BEEF, 4, 2);
        run_txn(3'd1, 32'h0000_4000, 32'hDEAD_BEEF, 4, 2);
        done_cnt = 0;
        for (int c = 0; c < W; c++) if (obs_done[c] === 1'b1) done_cnt++;
        for (int c = 1; c <= 5; c++) begin
            n_total++; if (obs_req[c] !== 1'b1) $display("FAIL drain req_c%0d got %b exp 1", c, obs_req[c]); else n_pass++;
        end
        n_total++; if (obs_req[6] !== 1'b0) $display("FAIL drain req_c6 got %b exp 0", obs_req[6]); else n_pass++;
        n_total++; if (obs_busy[4] !== 1'b1) $display("FAIL drain busy_c4 got %b exp 1", obs_busy[4]); else n_pass++;
        n_total++; if (done_cnt != 0) $display("FAIL drain done_cycles got %0d exp 0", done_cnt); else n_pass++;
        n_total++; if (obs_load[W-1] !== prev) $display("FAIL drain LoadD got %h exp %h", obs_load[W-1], prev); else n_pass++;

        // Flush in the very cycle the ack arrives.
        build_expect(3'd1, 32'h0000_4100, 32'h0BAD_F00D, 2, 3);
        run_txn(3'd1, 32'h0000_4100, 32'h0BAD_F00D, 2, 3);
        n_total++; if (obs_done[4] !== 1'b0) $display("FAIL flush_ack done_c4 got %b exp 0", obs_done[4]); else n_pass++;
        n_total++; if (obs_req[4] !== 1'b0) $display("FAIL flush_ack req_c4 got %b exp 0", obs_req[4]); else n_pass++;
        n_total++; if (obs_load[5] !== prev) $display("FAIL flush_ack LoadD got %h exp %h", obs_load[5], prev); else n_pass++;

        // Flush in the acceptance cycle: load ignored.
        build_expect(3'd1, 32'h0000_4200, 32'h1111_1111, 0, 0);
        run_txn(3'd1, 32'h0000_4200, 32'h1111_1111, 0, 0);
        n_total++; if (obs_busy[0] !== 1'b0) $display("FAIL flush_acc busy_c0 got %b exp 0", obs_busy[0]); else n_pass++;
        n_total++; if (obs_req[1] !== 1'b0) $display("FAIL flush_acc req_c1 got %b exp 0", obs_req[1]); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [31:0] prev;
        prev = cur_load;
        build_expect(3'd1, 32'h0000_5000, 32'h5555_AAAA, TIMEOUT + 5, -1);
        run_txn(3'd1, 32'h0000_5000, 32'h5555_AAAA, TIMEOUT + 5, -1);
        n_total++; if (obs_req[TIMEOUT] !== 1'b1) $display("FAIL timeout req_last got %b exp 1", obs_req[TIMEOUT]); else n_pass++;
        n_total++; if (obs_req[TIMEOUT+1] !== 1'b0) $display("FAIL timeout req_drop got %b exp 0", obs_req[TIMEOUT+1]); else n_pass++;
        n_total++; if (obs_berr[TIMEOUT] !== 1'b0) $display("FAIL timeout BusErr_early got %b exp 0", obs_berr[TIMEOUT]); else n_pass++;
        n_total++; if (obs_berr[TIMEOUT+1] !== 1'b1) $display("FAIL timeout BusErr got %b exp 1", obs_berr[TIMEOUT+1]); else n_pass++;
        n_total++; if (obs_berr[TIMEOUT+2] !== 1'b0) $display("FAIL timeout BusErr_pulse got %b exp 0", obs_berr[TIMEOUT+2]); else n_pass++;
        n_total++; if (obs_load[W-1] !== prev) $display("FAIL timeout LoadD got %h exp %h", obs_load[W-1], prev); else n_pass++;

        build_expect(3'd1, 32'h0000_5004, 32'hCAFE_F00D, 1, -1);
        run_txn(3'd1, 32'h0000_5004, 32'hCAFE_F00D, 1, -1);
        n_total++; if (obs_done[3] !== 1'b1) $display("FAIL after_to done_c3 got %b exp 1", obs_done[3]); else n_pass++;
        n_total++; if (obs_load[3] !== 32'hCAFE_F00D) $display("FAIL after_to LoadD got %h exp cafef00d", obs_load[3]); else n_pass++;

        // Ack in the last cycle before the timeout still completes normally.
        build_expect(3'd3, 32'h0000_5006, 32'h4321_0000, TIMEOUT - 1, -1);
        run_txn(3'd3, 32'h0000_5006, 32'h4321_0000, TIMEOUT - 1, -1);
        n_total++; if (obs_berr[TIMEOUT+1] !== 1'b0) $display("FAIL late_ack BusErr got %b exp 0", obs_berr[TIMEOUT+1]); else n_pass++;
        n_total++; if (obs_done[TIMEOUT+1] !== 1'b1) $display("FAIL late_ack done got %b exp 1", obs_done[TIMEOUT+1]); else n_pass++;
        n_total++; if (obs_load[TIMEOUT+1] !== 32'h0000_4321) $display("FAIL late_ack LoadD got %h exp 00004321", obs_load[TIMEOUT+1]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(3'd1, 32'h0000_7000, 1'b0, 1'b0, 32'h0);
        n_total++; if (busy !== 1'b1) $display("FAIL b2b busy_c0 got %b exp 1", busy); else n_pass++;
        drive(3'd0, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
        n_total++; if (m_rd_req !== 1'b1) $display("FAIL b2b req_c1 got %b exp 1", m_rd_req); else n_pass++;
        n_total++; if (m_rd_addr !== 32'h0000_7000) $display("FAIL b2b addr_c1 got %h exp 00007000", m_rd_addr); else n_pass++;
        // LDOp held through the done cycle must not start a new load there.
        drive(3'd1, 32'h0000_7000, 1'b0, 1'b0, 32'h0);
        n_total++; if (done !== 1'b1) $display("FAIL b2b done_c2 got %b exp 1", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL b2b busy_c2 got %b exp 0", busy); else n_pass++;
        n_total++; if (LoadD !== 32'h1111_2222) $display("FAIL b2b LoadD1 got %h exp 11112222", LoadD); else n_pass++;
        drive(3'd5, 32'h0000_7105, 1'b0, 1'b0, 32'h0);
        n_total++; if (m_rd_req !== 1'b0) $display("FAIL b2b req_c3 got %b exp 0", m_rd_req); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL b2b busy_c3 got %b exp 1", busy); else n_pass++;
        drive(3'd0, 32'h0, 1'b0, 1'b1, 32'h0000_9C00);
        n_total++; if (m_rd_req !== 1'b1) $display("FAIL b2b req_c4 got %b exp 1", m_rd_req); else n_pass++;
        n_total++; if (m_rd_addr !== 32'h0000_7104) $display("FAIL b2b addr_c4 got %h exp 00007104", m_rd_addr); else n_pass++;
        drive(3'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_total++; if (done !== 1'b1) $display("FAIL b2b done_c5 got %b exp 1", done); else n_pass++;
        n_total++; if (LoadD !== 32'h0000_009C) $display("FAIL b2b LoadD2 got %h exp 0000009c", LoadD); else n_pass++;
        drive(3'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_total++; if (m_rd_req !== 1'b0) $display("FAIL b2b req_c6 got %b exp 0", m_rd_req); else n_pass++;
        cur_load = 32'h0000_009C;
    endtask

    task automatic test_reset_mid_wait();
        drive(3'd1, 32'h0000_6000, 1'b0, 1'b0, 32'h0);
        drive(3'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(3'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_total++; if (m_rd_req !== 1'b1) $display("FAIL rst_wait req_before got %b exp 1", m_rd_req); else n_pass++;
        #1;
        reset = 1'b0;
        #1;
        n_total++; if (m_rd_req !== 1'b0) $display("FAIL rst_wait m_rd_req got %b exp 0", m_rd_req); else n_pass++;
        n_total++; if (m_rd_addr !== 32'h0) $display("FAIL rst_wait m_rd_addr got %h exp 0", m_rd_addr); else n_pass++;
        n_total++; if (LoadD !== 32'h0) $display("FAIL rst_wait LoadD got %h exp 0", LoadD); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_wait busy got %b exp 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_wait done got %b exp 0", done); else n_pass++;
        n_total++; if (AdEL !== 1'b0 || BusErr !== 1'b0) $display("FAIL rst_wait pulses got %b%b exp 00", AdEL, BusErr); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        cur_load = 32'h0;
        build_expect(3'd1, 32'h0000_6008, 32'h1234_5678, 2, -1);
        run_txn(3'd1, 32'h0000_6008, 32'h1234_5678, 2, -1);
        n_total++; if (obs_load[0] !== 32'h0) $display("FAIL rst_after LoadD_c0 got %h exp 0", obs_load[0]); else n_pass++;
        n_total++; if (obs_done[4] !== 1'b1) $display("FAIL rst_after done_c4 got %b exp 1", obs_done[4]); else n_pass++;
        n_total++; if (obs_load[4] !== 32'h1234_5678) $display("FAIL rst_after LoadD got %h exp 12345678", obs_load[4]); else n_pass++;
    endtask

    task automatic test_random();
        int          dtab[8];
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] got;
        int          d;
        int          f;
        dtab = '{0, 1, 2, 3, 5, TIMEOUT - 1, TIMEOUT, TIMEOUT + 2};
        exp_q.delete();
        for (int t = 0; t < 40; t++) begin
            op   = 3'($urandom_range(0, 7));
            addr = $urandom();
            data = $urandom();
            d    = dtab[$urandom_range(0, 7)];
            f    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            build_expect(op, addr, data, d, f);
            if (exp_has_done) exp_q.push_back(exp_res);
            run_txn(op, addr, data, d, f);
            for (int c = 0; c < W; c++) begin
                n_total++; if (obs_req[c] !== exp_req[c]) $display("FAIL rnd%0d c%0d m_rd_req got %b exp %b", t, c, obs_req[c], exp_req[c]); else n_pass++;
                n_total++; if (obs_busy[c] !== exp_busy[c]) $display("FAIL rnd%0d c%0d busy got %b exp %b", t, c, obs_busy[c], exp_busy[c]); else n_pass++;
                n_total++; if (obs_done[c] !== exp_done[c]) $display("FAIL rnd%0d c%0d done got %b exp %b", t, c, obs_done[c], exp_done[c]); else n_pass++;
                n_total++; if (obs_adel[c] !== exp_adel[c]) $display("FAIL rnd%0d c%0d AdEL got %b exp %b", t, c, obs_adel[c], exp_adel[c]); else n_pass++;
                n_total++; if (obs_berr[c] !== exp_berr[c]) $display("FAIL rnd%0d c%0d BusErr got %b exp %b", t, c, obs_berr[c], exp_berr[c]); else n_pass++;
                n_total++; if (obs_load[c] !== exp_load[c]) $display("FAIL rnd%0d c%0d LoadD got %h exp %h", t, c, obs_load[c], exp_load[c]); else n_pass++;
                if (exp_req[c]) begin
                    n_total++; if (obs_addr[c] !== exp_addr) $display("FAIL rnd%0d c%0d m_rd_addr got %h exp %h", t, c, obs_addr[c], exp_addr); else n_pass++;
                end
                if (obs_done[c] === 1'b1) begin
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL rnd%0d c%0d scoreboard got done exp none", t, c);
                    end else begin
                        got = exp_q.pop_front();
                        if (obs_load[c] !== got) $display("FAIL rnd%0d c%0d sb_LoadD got %h exp %h", t, c, obs_load[c], got);
                        else n_pass++;
                    end
                end
            end
            n_total++; if (exp_q.size() != 0) begin $display("FAIL rnd%0d scoreboard left %0d exp 0", t, exp_q.size()); exp_q.delete(); end else n_pass++;
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_byte_loads();
        test_half_loads();
        test_misaligned();
        test_flush();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
